// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared types and constants for the two-requester AXI write arbiter
//   owner_t  - index of the requester (0 or 1) that owns a burst
//   state_t  - arbiter FSM states
//   BURST_*  - AXI AWBURST encodings
package axi_arb_pkg;
  typedef logic owner_t;
  typedef enum logic {IDLE, BURST} state_t;
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
endpackage

// File: rtl/arb_owner_fifo.sv
// arb_owner_fifo: DEPTH-deep, 1-bit-wide FIFO of burst owners awaiting their B response
//   clk, resetn      - clock, synchronous active-low reset (empties the FIFO)
//   i_push, i_din    - push owner index
//   i_pop            - pop head entry
//   o_dout           - head entry
//   o_full, o_empty  - occupancy flags
module arb_owner_fifo
  import axi_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_push,
  input  logic i_din,
  input  logic i_pop,
  output logic o_dout,
  output logic o_full,
  output logic o_empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  owner_t r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0] r_cnt;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + PW'(i_push);
      r_rp  <= r_rp + PW'(i_pop);
      r_cnt <= r_cnt + (PW+1)'(i_push) - (PW+1)'(i_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp] <= i_din;
  end
  assign o_dout  = r_mem[r_rp];
  assign o_full  = r_cnt == (PW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
endmodule

// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: round-robin arbiter sharing one AXI4 write slave between two requesters
//   clk, resetn      - clock, synchronous active-low reset
//   S0_*/S1_*        - requester-side AW/W/B channels
//   M_AXI_*          - slave-side AW/W/B channels
//   grant            - one-hot owner of the current burst, 00 when idle
// Grants are made per burst on AWVALID; AW and W of the owner pass through
// independently, and the owner FIFO routes each B back to its issuer.
module axi_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int DW          = 512,
  parameter int AW          = 16,
  parameter int OUTSTANDING = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [AW-1:0]   S0_AWADDR,
  input  logic [7:0]      S0_AWLEN,
  input  logic [2:0]      S0_AWSIZE,
  input  logic [1:0]      S0_AWBURST,
  input  logic            S0_AWVALID,
  output logic            S0_AWREADY,
  input  logic [DW-1:0]   S0_WDATA,
  input  logic [DW/8-1:0] S0_WSTRB,
  input  logic            S0_WLAST,
  input  logic            S0_WVALID,
  output logic            S0_WREADY,
  output logic [1:0]      S0_BRESP,
  output logic            S0_BVALID,
  input  logic            S0_BREADY,
  input  logic [AW-1:0]   S1_AWADDR,
  input  logic [7:0]      S1_AWLEN,
  input  logic [2:0]      S1_AWSIZE,
  input  logic [1:0]      S1_AWBURST,
  input  logic            S1_AWVALID,
  output logic            S1_AWREADY,
  input  logic [DW-1:0]   S1_WDATA,
  input  logic [DW/8-1:0] S1_WSTRB,
  input  logic            S1_WLAST,
  input  logic            S1_WVALID,
  output logic            S1_WREADY,
  output logic [1:0]      S1_BRESP,
  output logic            S1_BVALID,
  input  logic            S1_BREADY,
  output logic [AW-1:0]   M_AXI_AWADDR,
  output logic [7:0]      M_AXI_AWLEN,
  output logic [2:0]      M_AXI_AWSIZE,
  output logic [1:0]      M_AXI_AWBURST,
  output logic            M_AXI_AWVALID,
  input  logic            M_AXI_AWREADY,
  output logic [DW-1:0]   M_AXI_WDATA,
  output logic [DW/8-1:0] M_AXI_WSTRB,
  output logic            M_AXI_WLAST,
  output logic            M_AXI_WVALID,
  input  logic            M_AXI_WREADY,
  input  logic [1:0]      M_AXI_BRESP,
  input  logic            M_AXI_BVALID,
  output logic            M_AXI_BREADY,
  output logic [1:0]      grant
);
  state_t r_state, w_state_n;
  owner_t r_owner, w_owner_n, r_last, w_last_n, w_head;
  logic r_aw_done, w_aw_done_n, r_w_done, w_w_done_n;
  logic w_burst, w_aw_hs, w_w_hs, w_b_hs, w_full, w_empty;
  assign w_burst = r_state == BURST;
  assign M_AXI_AWADDR  = !w_burst ? '0 : r_owner ? S1_AWADDR  : S0_AWADDR;
  assign M_AXI_AWLEN   = !w_burst ? '0 : r_owner ? S1_AWLEN   : S0_AWLEN;
  assign M_AXI_AWSIZE  = !w_burst ? '0 : r_owner ? S1_AWSIZE  : S0_AWSIZE;
  assign M_AXI_AWBURST = !w_burst ? '0 : r_owner ? S1_AWBURST : S0_AWBURST;
  assign M_AXI_WDATA   = !w_burst ? '0 : r_owner ? S1_WDATA   : S0_WDATA;
  assign M_AXI_WSTRB   = !w_burst ? '0 : r_owner ? S1_WSTRB   : S0_WSTRB;
  assign M_AXI_WLAST   = w_burst && (r_owner ? S1_WLAST : S0_WLAST);
  // Each channel closes independently once its own handshake has completed.
  assign M_AXI_AWVALID = w_burst && !r_aw_done && (r_owner ? S1_AWVALID : S0_AWVALID);
  assign M_AXI_WVALID  = w_burst && !r_w_done && (r_owner ? S1_WVALID : S0_WVALID);
  assign S0_AWREADY = w_burst && !r_owner && !r_aw_done && M_AXI_AWREADY;
  assign S1_AWREADY = w_burst && r_owner && !r_aw_done && M_AXI_AWREADY;
  assign S0_WREADY  = w_burst && !r_owner && !r_w_done && M_AXI_WREADY;
  assign S1_WREADY  = w_burst && r_owner && !r_w_done && M_AXI_WREADY;
  assign w_aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_w_hs  = M_AXI_WVALID && M_AXI_WREADY && M_AXI_WLAST;
  // With no burst outstanding a stray B is left stalled rather than dropped.
  assign M_AXI_BREADY = !w_empty && (w_head ? S1_BREADY : S0_BREADY);
  assign S0_BVALID = !w_empty && !w_head && M_AXI_BVALID;
  assign S1_BVALID = !w_empty && w_head && M_AXI_BVALID;
  assign S0_BRESP  = M_AXI_BRESP;
  assign S1_BRESP  = M_AXI_BRESP;
  assign w_b_hs    = M_AXI_BVALID && M_AXI_BREADY;
  assign grant     = {w_burst && r_owner, w_burst && !r_owner};
  always_comb begin
    w_state_n   = r_state;
    w_owner_n   = r_owner;
    w_last_n    = r_last;
    w_aw_done_n = r_aw_done || w_aw_hs;
    w_w_done_n  = r_w_done || w_w_hs;
    if (r_state == IDLE) begin
      w_aw_done_n = 1'b0;
      w_w_done_n  = 1'b0;
      if (!w_full && (S0_AWVALID || S1_AWVALID)) begin
        w_state_n = BURST;
        w_owner_n = (S0_AWVALID && S1_AWVALID) ? !r_last : S1_AWVALID;
      end
    end else if (w_aw_done_n && w_w_done_n) begin
      w_state_n = IDLE;
      w_last_n  = r_owner;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_owner   <= w_owner_n;
      r_last    <= w_last_n;
      r_aw_done <= w_aw_done_n;
      r_w_done  <= w_w_done_n;
    end
  end
  arb_owner_fifo #(.DEPTH(OUTSTANDING)) u_owner_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_aw_hs),
    .i_din   (r_owner),
    .i_pop   (w_b_hs),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb_axi_wr_arbiter: randomized bench comparing axi_wr_arbiter against a burst-level reference model
module tb_axi_wr_arbiter;
  localparam int DW = 64, AW = 16, SW = DW/8, OUT = 4;
  logic clk = 0, resetn = 0;
  logic [AW-1:0] s_awaddr[2];
  logic [7:0] s_awlen[2];
  logic [2:0] s_awsize[2];
  logic [1:0] s_awburst[2];
  logic s_awvalid[2], s_awready[2];
  logic [DW-1:0] s_wdata[2];
  logic [SW-1:0] s_wstrb[2];
  logic s_wlast[2], s_wvalid[2], s_wready[2];
  logic [1:0] s_bresp[2];
  logic s_bvalid[2], s_bready[2];
  logic [AW-1:0] m_awaddr;
  logic [7:0] m_awlen;
  logic [2:0] m_awsize;
  logic [1:0] m_awburst;
  logic m_awvalid, m_awready = 0;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic m_wlast, m_wvalid, m_wready = 0;
  logic [1:0] m_bresp = 0;
  logic m_bvalid = 0, m_bready;
  logic [1:0] grant;

  axi_wr_arbiter #(.DW(DW), .AW(AW), .OUTSTANDING(OUT)) dut (
    .clk(clk), .resetn(resetn),
    .S0_AWADDR(s_awaddr[0]), .S0_AWLEN(s_awlen[0]), .S0_AWSIZE(s_awsize[0]), .S0_AWBURST(s_awburst[0]),
    .S0_AWVALID(s_awvalid[0]), .S0_AWREADY(s_awready[0]),
    .S0_WDATA(s_wdata[0]), .S0_WSTRB(s_wstrb[0]), .S0_WLAST(s_wlast[0]), .S0_WVALID(s_wvalid[0]), .S0_WREADY(s_wready[0]),
    .S0_BRESP(s_bresp[0]), .S0_BVALID(s_bvalid[0]), .S0_BREADY(s_bready[0]),
    .S1_AWADDR(s_awaddr[1]), .S1_AWLEN(s_awlen[1]), .S1_AWSIZE(s_awsize[1]), .S1_AWBURST(s_awburst[1]),
    .S1_AWVALID(s_awvalid[1]), .S1_AWREADY(s_awready[1]),
    .S1_WDATA(s_wdata[1]), .S1_WSTRB(s_wstrb[1]), .S1_WLAST(s_wlast[1]), .S1_WVALID(s_wvalid[1]), .S1_WREADY(s_wready[1]),
    .S1_BRESP(s_bresp[1]), .S1_BVALID(s_bvalid[1]), .S1_BREADY(s_bready[1]),
    .M_AXI_AWADDR(m_awaddr), .M_AXI_AWLEN(m_awlen), .M_AXI_AWSIZE(m_awsize), .M_AXI_AWBURST(m_awburst),
    .M_AXI_AWVALID(m_awvalid), .M_AXI_AWREADY(m_awready),
    .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb), .M_AXI_WLAST(m_wlast), .M_AXI_WVALID(m_wvalid), .M_AXI_WREADY(m_wready),
    .M_AXI_BRESP(m_bresp), .M_AXI_BVALID(m_bvalid), .M_AXI_BREADY(m_bready),
    .grant(grant)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: current owner (-1 idle), last winner, channel completion, owners awaiting B
  int m_own = -1;
  bit m_last = 1, m_awd = 0, m_wd = 0, mon_on = 0;
  int q_own[$];
  // observations shared with the stimulus driver
  bit aw_hs_s[2], w_hs_s[2], m_aw_hs_s, m_b_hs_s, rst_seen;
  int b_rx[2], w_beats = 0, m_aw_cnt = 0;
  logic [1:0] rx0[$], rx1[$], resp_q[$];
  bit g_seq[$];
  logic [1:0] prev_g = 0;

  task automatic sample();
    int o = m_own;
    bit idle = (o < 0);
    int oi = idle ? 0 : o;
    int hd = (q_own.size() > 0) ? q_own[0] : -1;
    bit full = q_own.size() >= OUT;
    logic [1:0] eg = idle ? 2'b00 : (o == 1 ? 2'b10 : 2'b01);
    bit eawv = !idle && !m_awd && s_awvalid[oi];
    bit ewv = !idle && !m_wd && s_wvalid[oi];
    bit ebr = (hd >= 0) && s_bready[hd < 0 ? 0 : hd];
    logic [28:0] eaw = idle ? 29'd0 : {s_awaddr[oi], s_awlen[oi], s_awsize[oi], s_awburst[oi]};
    logic [72:0] ew = idle ? 73'd0 : {s_wdata[oi], s_wstrb[oi], s_wlast[oi]};
    bit awhs = eawv && m_awready;
    bit whs = ewv && m_wready && s_wlast[oi];
    bit bhs = m_bvalid && ebr;
    chk("grant", grant, eg);
    chk("m_awvalid", m_awvalid, eawv);
    chk("m_wvalid", m_wvalid, ewv);
    chk("m_aw_payload", {m_awaddr, m_awlen, m_awsize, m_awburst}, eaw);
    chk("m_w_payload", {m_wdata, m_wstrb, m_wlast}, ew);
    chk("m_bready", m_bready, ebr);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("s%0d_awready", i), s_awready[i], !idle && o == i && !m_awd && m_awready);
      chk($sformatf("s%0d_wready", i), s_wready[i], !idle && o == i && !m_wd && m_wready);
      chk($sformatf("s%0d_bvalid", i), s_bvalid[i], hd == i && m_bvalid);
      if (hd == i && m_bvalid) chk($sformatf("s%0d_bresp", i), s_bresp[i], m_bresp);
    end
    rst_seen = !resetn;
    for (int i = 0; i < 2; i++) begin
      aw_hs_s[i] = resetn && s_awvalid[i] && s_awready[i];
      w_hs_s[i] = resetn && s_wvalid[i] && s_wready[i];
      if (resetn && s_bvalid[i] && s_bready[i]) begin
        b_rx[i]++;
        if (i == 0) rx0.push_back(s_bresp[0]); else rx1.push_back(s_bresp[1]);
      end
    end
    m_aw_hs_s = resetn && m_awvalid && m_awready;
    m_b_hs_s = resetn && m_bvalid && m_bready;
    if (m_aw_hs_s) m_aw_cnt++;
    if (resetn && m_wvalid && m_wready) w_beats++;
    if (resetn && grant != 0 && prev_g == 0) g_seq.push_back(grant[1]);
    prev_g = grant;
    if (!resetn) begin
      m_own = -1; m_last = 1; m_awd = 0; m_wd = 0; q_own.delete();
    end else begin
      if (bhs) void'(q_own.pop_front());
      if (idle) begin
        if (!full && (s_awvalid[0] || s_awvalid[1])) begin
          m_own = (s_awvalid[0] && s_awvalid[1]) ? (m_last ? 0 : 1) : (s_awvalid[1] ? 1 : 0);
          m_awd = 0; m_wd = 0;
        end
      end else begin
        if (awhs) q_own.push_back(o);
        m_awd |= awhs;
        m_wd |= whs;
        if (m_awd && m_wd) begin m_last = (o == 1); m_own = -1; end
      end
    end
  endtask

  always @(negedge clk) if (mon_on) sample();

  // stimulus knobs (percent probabilities) and requester / slave state
  int p_start = 100, p_aw[2] = '{100, 100}, p_w[2] = '{100, 100}, p_br[2] = '{100, 100};
  int p_awr = 100, p_wr = 100, p_bv = 100, fix_len = -1, aw_dly[2] = '{0, 0};
  bit act[2], aw_sent[2], w_all[2];
  int beat[2], len[2], dcnt[2], issued[2], tgt[2], pending = 0;

  function automatic bit rnd(int p);
    return $urandom_range(0, 99) < p;
  endfunction

  task automatic drive();
    if (rst_seen) begin
      for (int i = 0; i < 2; i++) begin
        act[i] = 0; s_awvalid[i] = 0; s_wvalid[i] = 0;
      end
      m_bvalid = 0; pending = 0;
    end
    for (int i = 0; i < 2; i++) begin
      if (aw_hs_s[i]) begin aw_sent[i] = 1; s_awvalid[i] = 0; end
      if (w_hs_s[i]) begin
        beat[i]++; s_wvalid[i] = 0;
        if (beat[i] > len[i]) w_all[i] = 1;
      end
      if (act[i] && aw_sent[i] && w_all[i]) act[i] = 0;
      if (!act[i] && issued[i] < tgt[i] && rnd(p_start)) begin
        act[i] = 1; aw_sent[i] = 0; w_all[i] = 0; beat[i] = 0; dcnt[i] = 0;
        len[i] = fix_len >= 0 ? fix_len : $urandom_range(0, 15);
        issued[i]++;
      end
      if (act[i]) begin
        dcnt[i]++;
        if (!aw_sent[i] && !s_awvalid[i] && dcnt[i] > aw_dly[i] && rnd(p_aw[i])) begin
          s_awvalid[i] = 1; s_awaddr[i] = AW'($urandom); s_awlen[i] = 8'(len[i]);
          s_awsize[i] = 3'd3; s_awburst[i] = 2'd1;
        end
        if (!w_all[i] && !s_wvalid[i] && rnd(p_w[i])) begin
          s_wvalid[i] = 1; s_wdata[i] = {$urandom, $urandom}; s_wstrb[i] = SW'($urandom);
          s_wlast[i] = (beat[i] == len[i]);
        end
      end
      s_bready[i] = rnd(p_br[i]);
    end
    m_awready = rnd(p_awr);
    m_wready = rnd(p_wr);
    if (m_aw_hs_s) pending++;
    if (m_b_hs_s) begin pending--; m_bvalid = 0; end
    if (!m_bvalid && pending > 0 && rnd(p_bv)) begin
      m_bvalid = 1;
      m_bresp = (resp_q.size() > 0) ? resp_q.pop_front() : 2'($urandom_range(0, 3));
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1 drive();
  end

  task automatic knobs(int p, int bv);
    p_start = p; p_awr = p; p_wr = p; p_bv = bv;
    for (int i = 0; i < 2; i++) begin p_aw[i] = p; p_w[i] = p; p_br[i] = p; end
  endtask

  task automatic start(int n0, int n1);
    tgt[0] = issued[0] + n0;
    tgt[1] = issued[1] + n1;
  endtask

  task automatic wait_idle(string tag, int budget, bit drain);
    int n = 0;
    while (n < budget && !(issued[0] == tgt[0] && issued[1] == tgt[1] && !act[0] && !act[1] &&
           (!drain || (q_own.size() == 0 && pending == 0 && !m_bvalid)))) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_finished_in_budget"}, n < budget, 1'b1);
  endtask

  task automatic do_reset(string tag);
    p_br[0] = 100; p_br[1] = 100;
    @(posedge clk); #1 resetn = 0;
    @(posedge clk); #1 resetn = 1;
    @(negedge clk);
    chk({tag, "_rst_grant"}, grant, 2'b00);
    chk({tag, "_rst_ctl"}, {m_awvalid, m_wvalid, m_bready, s_awready[0], s_awready[1],
        s_wready[0], s_wready[1], s_bvalid[0], s_bvalid[1]}, 9'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int b0, b1, wb, a, n;
    for (int i = 0; i < 2; i++) begin
      s_awvalid[i] = 0; s_wvalid[i] = 0; s_bready[i] = 0; s_awaddr[i] = 0; s_awlen[i] = 0;
      s_awsize[i] = 0; s_awburst[i] = 0; s_wdata[i] = 0; s_wstrb[i] = 0; s_wlast[i] = 0;
    end
    @(posedge clk); #1 mon_on = 1;
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    @(negedge clk);
    chk("init_grant", grant, 2'b00);

    // single requester, 16 x 64-beat bursts, slave always ready
    knobs(100, 100); fix_len = 63;
    b0 = b_rx[0]; b1 = b_rx[1]; wb = w_beats;
    start(16, 0);
    wait_idle("p1", 5000, 1);
    chk("p1_w_beats", w_beats - wb, 1024);
    chk("p1_b_s0", b_rx[0] - b0, 16);
    chk("p1_b_s1", b_rx[1] - b1, 0);

    // contention right after reset: strict alternation starting with S0
    do_reset("p2");
    fix_len = -1; g_seq.delete();
    start(8, 8);
    wait_idle("p2", 3000, 1);
    chk("p2_grants", g_seq.size(), 16);
    for (int k = 0; k < g_seq.size(); k++) chk($sformatf("p2_order%0d", k), g_seq[k], k % 2);

    // S1 offers W data while AWVALID is delayed 5 cycles
    do_reset("p3");
    fix_len = 3; aw_dly[1] = 5; wb = w_beats; b1 = b_rx[1];
    start(0, 1);
    wait_idle("p3", 500, 1);
    chk("p3_w_beats", w_beats - wb, 4);
    chk("p3_b_s1", b_rx[1] - b1, 1);
    aw_dly[1] = 0;

    // B withheld: the fifth burst must wait for the first response
    do_reset("p4");
    fix_len = 1; p_bv = 0; a = m_aw_cnt;
    start(5, 0);
    repeat (60) @(negedge clk);
    chk("p4_aw_accepted", m_aw_cnt - a, 4);
    chk("p4_s0_awvalid", s_awvalid[0], 1'b1);
    chk("p4_s0_awready", s_awready[0], 1'b0);
    chk("p4_grant_idle", grant, 2'b00);
    p_bv = 100;
    wait_idle("p4", 500, 1);
    chk("p4_aw_total", m_aw_cnt - a, 5);

    // B routing S0,S1,S0 with OKAY/SLVERR/OKAY and a stalled head
    do_reset("p5");
    fix_len = 0; p_bv = 0; rx0.delete(); rx1.delete();
    resp_q.delete(); resp_q.push_back(2'd0); resp_q.push_back(2'd2); resp_q.push_back(2'd0);
    start(1, 0); wait_idle("p5a", 200, 0);
    start(0, 1); wait_idle("p5b", 200, 0);
    start(1, 0); wait_idle("p5c", 200, 0);
    p_br[0] = 0; p_bv = 100;
    repeat (10) @(negedge clk);
    chk("p5_stall_m_bready", m_bready, 1'b0);
    chk("p5_stall_m_bvalid", m_bvalid, 1'b1);
    chk("p5_stall_s0_bvalid", s_bvalid[0], 1'b1);
    chk("p5_stall_s1_bvalid", s_bvalid[1], 1'b0);
    p_br[0] = 100;
    wait_idle("p5", 200, 1);
    chk("p5_s0_count", rx0.size(), 2);
    chk("p5_s1_count", rx1.size(), 1);
    if (rx0.size() == 2) begin
      chk("p5_s0_resp0", rx0[0], 2'd0);
      chk("p5_s0_resp1", rx0[1], 2'd0);
    end
    if (rx1.size() == 1) chk("p5_s1_resp", rx1[0], 2'd2);

    // reset in the middle of a 64-beat burst, then a clean S1 burst
    do_reset("p6");
    fix_len = 63; wb = w_beats; n = 0;
    start(1, 0);
    while (w_beats - wb < 10 && n < 500) begin @(negedge clk); n++; end
    chk("p6_reached_beat10", w_beats - wb, 10);
    do_reset("p6_mid");
    chk("p6_fifo_empty_bready", m_bready, 1'b0);
    fix_len = 7; b1 = b_rx[1]; wb = w_beats;
    start(0, 1);
    wait_idle("p6", 500, 1);
    chk("p6_s1_b", b_rx[1] - b1, 1);
    chk("p6_s1_beats", w_beats - wb, 8);

    // fully random traffic and backpressure
    fix_len = -1;
    for (int r = 0; r < 3; r++) begin
      knobs($urandom_range(40, 100), $urandom_range(20, 100));
      b0 = b_rx[0]; b1 = b_rx[1];
      start(20, 20);
      wait_idle($sformatf("p7_%0d", r), 8000, 1);
      chk($sformatf("p7_%0d_b_s0", r), b_rx[0] - b0, 20);
      chk($sformatf("p7_%0d_b_s1", r), b_rx[1] - b1, 20);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
